// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the load/store bus between the core's mem_unit
// and the data memory responder.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic MEM_READ  = 1'b1;
  localparam logic MEM_WRITE = 1'b0;

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned NUM_LANES = 4;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0000_0000;

endpackage

// File: rtl/data_mem_responder_ram.sv
// Single-port word RAM with per-byte write enables and a registered read port.
// The array is deliberately not reset so it maps onto block RAM.
module data_mem_responder_ram
  import mem_bus_pkg::*;
#(
  parameter  int unsigned DEPTH_WORDS = 1024,
  localparam int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic                 clk,
  input  logic [NUM_LANES-1:0] we,
  input  logic [AW-1:0]        addr,
  input  logic [31:0]          wdata,
  output logic [31:0]          rdata
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;

  // Read-before-write on a same-address collision; the responder never relies on it.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_LANES; i++) begin
      if (we[i]) begin
        mem_q[addr][i*BYTE_W +: BYTE_W] <= wdata[i*BYTE_W +: BYTE_W];
      end
    end
    rdata_q <= mem_q[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Bus-side responder for the core's load/store port: accepts one request at a
// time and completes it after a fixed number of wait states with a mem_valid pulse.
module data_mem_responder
  import mem_bus_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS   = 1024,
  parameter logic [31:0] BASE_ADDR     = DEFAULT_BASE_ADDR,
  parameter int unsigned READ_LATENCY  = 2,
  parameter int unsigned WRITE_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        mem_rd_wr,
  input  logic [3:0]  mask,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_write_data,
  output logic [31:0] mem_read_data,
  output logic        mem_valid,
  output logic        mem_err
);

  localparam int unsigned AW      = $clog2(DEPTH_WORDS);
  localparam int unsigned MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_LATENCY - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WRITE_LATENCY - 1);
  localparam logic [31-AW-2:0] BASE_HI = BASE_ADDR[31:AW+2];

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              req_rd_q, req_rd_d;
  logic [3:0]        req_mask_q, req_mask_d;
  logic [AW-1:0]     req_idx_q, req_idx_d;
  logic              req_err_q, req_err_d;
  logic [31:0]       req_wdata_q, req_wdata_d;
  logic [31:0]       last_rdata_q, last_rdata_d;

  logic [AW-1:0]     addr_idx;
  logic              addr_err;
  logic [CNT_W-1:0]  lat_load;
  logic [AW-1:0]     ram_addr;
  logic [3:0]        ram_we;
  logic [31:0]       ram_rdata;
  logic              resp_rd;
  logic              unused_addr_lsbs;

  // BASE_ADDR is aligned to the window size, so the window test and the word
  // index reduce to slicing the byte address.
  assign addr_idx         = mem_addr[AW+1:2];
  assign addr_err         = (mem_addr[31:AW+2] != BASE_HI);
  assign unused_addr_lsbs = ^mem_addr[1:0];
  assign lat_load         = (mem_rd_wr == MEM_READ) ? RD_LOAD : WR_LOAD;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_rd_d    = req_rd_q;
    req_mask_d  = req_mask_q;
    req_idx_d   = req_idx_q;
    req_err_d   = req_err_q;
    req_wdata_d = req_wdata_q;
    case (state_q)
      IDLE: begin
        if (cs) begin
          req_rd_d    = mem_rd_wr;
          req_mask_d  = mask;
          req_idx_d   = addr_idx;
          req_err_d   = addr_err;
          req_wdata_d = mem_write_data;
          cnt_d       = lat_load;
          state_d     = (lat_load == '0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // A latency-1 read must address the RAM straight from the bus in the accept cycle.
  assign ram_addr = (state_q == IDLE) ? addr_idx : req_idx_q;
  assign ram_we   = (state_q == RESP && req_rd_q == MEM_WRITE && !req_err_q) ? req_mask_q : 4'b0000;
  assign resp_rd  = (state_q == RESP) && (req_rd_q == MEM_READ);

  assign mem_read_data = resp_rd ? (req_err_q ? 32'h0 : ram_rdata) : last_rdata_q;
  assign last_rdata_d  = mem_read_data;
  assign mem_valid     = (state_q == RESP);
  assign mem_err       = (state_q == RESP) && req_err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      req_rd_q     <= MEM_READ;
      req_mask_q   <= '0;
      req_idx_q    <= '0;
      req_err_q    <= 1'b0;
      req_wdata_q  <= '0;
      last_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_rd_q     <= req_rd_d;
      req_mask_q   <= req_mask_d;
      req_idx_q    <= req_idx_d;
      req_err_q    <= req_err_d;
      req_wdata_q  <= req_wdata_d;
      last_rdata_q <= last_rdata_d;
    end
  end

  data_mem_responder_ram #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(req_wdata_q),
    .rdata(ram_rdata)
  );

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench: directed table, corner-case sequences and random traffic
// compared against a flat array model of the RAM window.
module tb_data_mem_responder;
  import mem_bus_pkg::*;

  localparam int DEPTH = 1024;
  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int RD_LAT = 2;
  localparam int WR_LAT = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, cs, mem_rd_wr, mem_valid, mem_err;
  logic [3:0]  mask;
  logic [31:0] mem_addr, mem_write_data, mem_read_data;

  logic        reset_b, cs_b, rdwr_b, valid_b, err_b;
  logic [3:0]  mask_b;
  logic [31:0] addr_b, wdata_b, rdata_b;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] model_mem [DEPTH];

  data_mem_responder dut (
    .clk(clk), .reset(reset), .cs(cs), .mem_rd_wr(mem_rd_wr), .mask(mask),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data), .mem_valid(mem_valid), .mem_err(mem_err)
  );

  data_mem_responder #(.WRITE_LATENCY(3)) dut_w3 (
    .clk(clk), .reset(reset_b), .cs(cs_b), .mem_rd_wr(rdwr_b), .mask(mask_b),
    .mem_addr(addr_b), .mem_write_data(wdata_b),
    .mem_read_data(rdata_b), .mem_valid(valid_b), .mem_err(err_b)
  );

  typedef struct {
    bit          rd;
    logic [3:0]  m;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    bit          exp_err;
    int          exp_lat;
  } vec_t;

  vec_t rows [$];

  function automatic bit in_range(input logic [31:0] a);
    longint unsigned la;
    la = {32'h0, a};
    return (la >= {32'h0, BASE}) && (la < {32'h0, BASE} + longint'(DEPTH) * 4);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (!in_range(a)) return 32'h0;
    return model_mem[(a - BASE) >> 2];
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
    int idx;
    if (!in_range(a)) return;
    idx = int'((a - BASE) >> 2);
    for (int i = 0; i < 4; i++) begin
      if (m[i]) model_mem[idx][i*8 +: 8] = d[i*8 +: 8];
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called on a negedge; drives one request and returns on the negedge after the pulse.
  task automatic applyStimulus(input bit rd, input logic [3:0] m, input logic [31:0] a,
                               input logic [31:0] wd, output bit seen, output int lat,
                               output logic [31:0] rdata, output logic err, output logic after);
    cs = 1'b1; mem_rd_wr = rd; mask = m; mem_addr = a; mem_write_data = wd;
    seen = 1'b0; lat = 0; rdata = 32'h0; err = 1'b0; after = 1'b0;
    for (int i = 1; i <= 16 && !seen; i++) begin
      @(negedge clk);
      if (i == 1) begin
        cs = 1'b0; mem_rd_wr = 1'($urandom); mask = 4'($urandom);
        mem_addr = $urandom; mem_write_data = $urandom;
      end
      if (mem_valid) begin
        seen = 1'b1; lat = i; rdata = mem_read_data; err = mem_err;
      end
    end
    @(negedge clk);
    after = mem_valid;
  endtask

  task automatic runAndCheck(input bit rd, input logic [3:0] m, input logic [31:0] a, input logic [31:0] wd);
    bit seen; int lat; logic [31:0] rdata; logic err, after;
    applyStimulus(rd, m, a, wd, seen, lat, rdata, err, after);
    checkOutput($sformatf("valid @%h", a), 32'(seen), 32'd1);
    checkOutput($sformatf("latency @%h", a), lat, rd ? RD_LAT : WR_LAT);
    checkOutput($sformatf("err @%h", a), 32'(err), 32'(!in_range(a)));
    if (rd) checkOutput($sformatf("rdata @%h", a), rdata, model_read(a));
    checkOutput($sformatf("pulse width @%h", a), 32'(after), 32'd0);
    if (!rd) model_write(a, m, wd);
  endtask

  task automatic reqB(input bit rd, input logic [31:0] a, input logic [31:0] wd,
                      output bit seen, output int lat, output logic [31:0] rdata);
    cs_b = 1'b1; rdwr_b = rd; mask_b = 4'hF; addr_b = a; wdata_b = wd;
    seen = 1'b0; lat = 0; rdata = 32'h0;
    for (int i = 1; i <= 16 && !seen; i++) begin
      @(negedge clk);
      if (i == 1) cs_b = 1'b0;
      if (valid_b) begin
        seen = 1'b1; lat = i; rdata = rdata_b;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: time limit reached before summary");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit seen; int lat; logic [31:0] rdata; logic err, after;
    int pulses;
    logic [31:0] b2b_addr [3];
    logic [31:0] a;

    reset = 1'b0; cs = 1'b0; mem_rd_wr = 1'b0; mask = 4'h0; mem_addr = 32'h0; mem_write_data = 32'h0;
    reset_b = 1'b0; cs_b = 1'b0; rdwr_b = 1'b0; mask_b = 4'h0; addr_b = 32'h0; wdata_b = 32'h0;
    #3;
    checkOutput("reset valid", 32'(mem_valid), 32'd0);
    checkOutput("reset err", 32'(mem_err), 32'd0);
    checkOutput("reset rdata", mem_read_data, 32'h0);
    checkOutput("reset valid w3", 32'(valid_b), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1; reset_b = 1'b1;
    @(negedge clk);
    checkOutput("post-reset valid", 32'(mem_valid), 32'd0);

    $display("[TB] prefilling RAM");
    for (int i = 0; i < DEPTH; i++) begin
      runAndCheck(1'b0, 4'hF, BASE + 32'(i * 4), $urandom);
    end

    rows.push_back('{1'b0, 4'hF, 32'h10,       32'hDEADBEEF, 32'h0,        1'b0, 1});
    rows.push_back('{1'b1, 4'h0, 32'h10,       32'h0,        32'hDEADBEEF, 1'b0, 2});
    rows.push_back('{1'b0, 4'hF, 32'h20,       32'h11223344, 32'h0,        1'b0, 1});
    rows.push_back('{1'b0, 4'h5, 32'h20,       32'hAABBCCDD, 32'h0,        1'b0, 1});
    rows.push_back('{1'b1, 4'hF, 32'h20,       32'h0,        32'h11BB33DD, 1'b0, 2});
    rows.push_back('{1'b1, 4'h0, 32'h1000,     32'h0,        32'h0,        1'b1, 2});
    rows.push_back('{1'b0, 4'hF, 32'h1000,     32'h12345678, 32'h0,        1'b1, 1});
    rows.push_back('{1'b0, 4'h0, 32'h10,       32'hFFFFFFFF, 32'h0,        1'b0, 1});
    rows.push_back('{1'b1, 4'h0, 32'h10,       32'h0,        32'hDEADBEEF, 1'b0, 2});
    rows.push_back('{1'b1, 4'h0, 32'h13,       32'h0,        32'hDEADBEEF, 1'b0, 2});
    rows.push_back('{1'b1, 4'h0, 32'hFFFFFFFC, 32'h0,        32'h0,        1'b1, 2});
    rows.push_back('{1'b0, 4'hF, 32'hFFC,      32'hCAFEF00D, 32'h0,        1'b0, 1});
    rows.push_back('{1'b1, 4'h0, 32'hFFC,      32'h0,        32'hCAFEF00D, 1'b0, 2});

    $display("[TB] directed table");
    foreach (rows[r]) begin
      applyStimulus(rows[r].rd, rows[r].m, rows[r].addr, rows[r].wdata, seen, lat, rdata, err, after);
      checkOutput($sformatf("row%0d valid", r), 32'(seen), 32'd1);
      checkOutput($sformatf("row%0d latency", r), lat, rows[r].exp_lat);
      checkOutput($sformatf("row%0d err", r), 32'(err), 32'(rows[r].exp_err));
      if (rows[r].rd) checkOutput($sformatf("row%0d rdata", r), rdata, rows[r].exp_rdata);
      checkOutput($sformatf("row%0d pulse width", r), 32'(after), 32'd0);
      if (!rows[r].rd) model_write(rows[r].addr, rows[r].m, rows[r].wdata);
    end

    $display("[TB] full scan after out-of-range write");
    for (int i = 0; i < DEPTH; i++) begin
      runAndCheck(1'b1, 4'h0, BASE + 32'(i * 4), 32'h0);
    end

    $display("[TB] back-to-back reads with cs held");
    b2b_addr[0] = 32'h0; b2b_addr[1] = 32'h4; b2b_addr[2] = 32'h8;
    pulses = 0;
    cs = 1'b1; mem_rd_wr = 1'b1; mask = 4'h0; mem_addr = b2b_addr[0];
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (mem_valid) begin
        checkOutput("b2b pulse cycle", c, 2 + 3 * pulses);
        if (pulses < 3) checkOutput("b2b rdata", mem_read_data, model_read(b2b_addr[pulses]));
        pulses++;
        if (pulses < 3) mem_addr = b2b_addr[pulses];
        else cs = 1'b0;
      end
    end
    cs = 1'b0;
    checkOutput("b2b pulse count", pulses, 3);

    $display("[TB] inputs changed while busy");
    cs = 1'b1; mem_rd_wr = 1'b1; mask = 4'h0; mem_addr = 32'h10;
    @(negedge clk);
    cs = 1'b0; mem_addr = 32'h20; mem_rd_wr = 1'b0; mask = 4'hF; mem_write_data = 32'h99999999;
    @(negedge clk);
    checkOutput("busy valid", 32'(mem_valid), 32'd1);
    checkOutput("busy rdata", mem_read_data, model_read(32'h10));
    @(negedge clk);
    checkOutput("busy pulse width", 32'(mem_valid), 32'd0);
    runAndCheck(1'b1, 4'h0, 32'h20, 32'h0);

    $display("[TB] random traffic");
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        a = $urandom;
        if (a < 32'h1000) a = a | 32'h1000;
      end else begin
        a = 32'($urandom_range(0, 4095));
      end
      runAndCheck(1'($urandom), 4'($urandom_range(0, 15)), a, $urandom);
    end

    $display("[TB] reset mid-transaction on WRITE_LATENCY=3 instance");
    reqB(1'b0, 32'h30, 32'h0BADCAFE, seen, lat, rdata);
    checkOutput("w3 write valid", 32'(seen), 32'd1);
    checkOutput("w3 write latency", lat, 3);
    pulses = 0;
    cs_b = 1'b1; rdwr_b = 1'b0; mask_b = 4'hF; addr_b = 32'h30; wdata_b = 32'h55AA55AA;
    @(negedge clk);
    cs_b = 1'b0;
    reset_b = 1'b0;
    #1;
    checkOutput("w3 state after reset", 32'(dut_w3.state_q), 32'(IDLE));
    checkOutput("w3 valid in reset", 32'(valid_b), 32'd0);
    @(negedge clk);
    if (valid_b) pulses++;
    reset_b = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (valid_b) pulses++;
    end
    checkOutput("w3 abandoned pulses", pulses, 0);
    reqB(1'b1, 32'h30, 32'h0, seen, lat, rdata);
    checkOutput("w3 read valid", 32'(seen), 32'd1);
    checkOutput("w3 read latency", lat, 2);
    checkOutput("w3 read old value", rdata, 32'h0BADCAFE);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
